// File: rtl/seq_alu_exec.sv
// Execution unit for the decoded 4-bit ALU control code: single-cycle logic/arith/compare,
// iterative one-bit-per-cycle shifts, start/done handshake with busy during shifts.
module seq_alu_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_t;

  state_t          r_state;
  kind_t           r_kind;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_result;
  logic            r_done;
  logic            r_busy;
  logic            r_illegal;

  logic [XLEN-1:0] w_one_cycle;
  logic            w_is_shift;
  logic [SHW-1:0]  w_shamt;
  kind_t           w_kind;

  function automatic logic [XLEN-1:0] shift_step(input kind_t kind, input logic [XLEN-1:0] v);
    logic [XLEN-1:0] res;
    case (kind)
      K_SLL:   res = {v[XLEN-2:0], 1'b0};
      K_SRL:   res = {1'b0, v[XLEN-1:1]};
      default: res = {v[XLEN-1], v[XLEN-1:1]};
    endcase
    return res;
  endfunction

  assign w_shamt    = b[SHW-1:0];
  assign w_is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

  always_comb begin
    w_kind = K_SRA;
    if (alu_ctrl == OP_SLL)      w_kind = K_SLL;
    else if (alu_ctrl == OP_SRL) w_kind = K_SRL;
  end

  // Shift codes land here only with shamt=0, where the result is a unchanged.
  always_comb begin
    w_one_cycle = '0;
    case (alu_ctrl)
      OP_ADD:                 w_one_cycle = a + b;
      OP_SUB:                 w_one_cycle = a - b;
      OP_AND:                 w_one_cycle = a & b;
      OP_OR:                  w_one_cycle = a | b;
      OP_XOR:                 w_one_cycle = a ^ b;
      OP_SLT:                 w_one_cycle = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL, OP_SRL, OP_SRA: w_one_cycle = a;
      default:                w_one_cycle = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_kind    <= K_SLL;
      r_cnt     <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_is_shift && (w_shamt != '0)) begin
              r_result  <= a;
              r_cnt     <= w_shamt;
              r_kind    <= w_kind;
              r_illegal <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= SHIFT;
            end else begin
              r_result  <= w_one_cycle;
              r_illegal <= (alu_ctrl > OP_XOR);
              r_done    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_result <= shift_step(r_kind, r_result);
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == SHW'(1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign illegal = r_illegal;
  assign zero    = (r_result == '0);

endmodule

// File: tb/tb_seq_alu_exec.sv
// Self-checking bench for seq_alu_exec: per-cycle comparison against a behavioural model,
// directed literal cases, and randomized traffic.
module tb_seq_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl = 4'd0;
  logic [31:0] ta = 32'd0;
  logic [31:0] tb = 32'd0;
  logic        busy, done, zero, illegal;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  seq_alu_exec #(.XLEN(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(ctrl), .a(ta), .b(tb),
    .busy(busy), .done(done), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: what the op yields after j shift steps (j = full shamt for the final value).
  function automatic logic [31:0] ref_op(input logic [3:0] c, input logic [31:0] x,
                                         input logic [31:0] y, input int j);
    case (c)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x << j;
      4'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: return x >> j;
      4'd7: return $unsigned($signed(x) >>> j);
      4'd8: return x ^ y;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural model state
  logic        e_busy = 1'b0, e_done = 1'b0, e_ill = 1'b0;
  logic [31:0] e_res = 32'd0;
  int          m_wait = 0, m_shamt = 0;
  logic [3:0]  m_ctrl = 4'd0;
  logic [31:0] m_a = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_busy = 1'b0; e_done = 1'b0; e_ill = 1'b0; e_res = 32'd0; m_wait = 0;
    end else begin
      e_done = 1'b0;
      if (m_wait > 0) begin
        m_wait = m_wait - 1;
        e_res  = ref_op(m_ctrl, m_a, 32'd0, m_shamt - m_wait);
        if (m_wait == 0) e_done = 1'b1;
      end else if (start) begin
        if ((ctrl == 4'd4 || ctrl == 4'd6 || ctrl == 4'd7) && tb[4:0] != 5'd0) begin
          m_ctrl  = ctrl;
          m_a     = ta;
          m_shamt = int'(tb[4:0]);
          m_wait  = m_shamt;
          e_res   = ta;
          e_ill   = 1'b0;
        end else begin
          e_res  = ref_op(ctrl, ta, tb, int'(tb[4:0]));
          e_ill  = (ctrl > 4'd8);
          e_done = 1'b1;
        end
      end
      e_busy = (m_wait > 0);
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", {31'd0, busy}, {31'd0, e_busy});
    check("cyc_done", {31'd0, done}, {31'd0, e_done});
    check("cyc_result", result, e_res);
    check("cyc_illegal", {31'd0, illegal}, {31'd0, e_ill});
    check("cyc_zero", {31'd0, zero}, {31'd0, (e_res == 32'd0)});
  end

  task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input logic ei, input int el);
    int lat, nb;
    @(negedge clk);
    start = 1'b1; ctrl = c; ta = x; tb = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1; nb = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    check({nm, "_done"}, {31'd0, done}, 32'd1);
    check({nm, "_lat"}, lat, el);
    check({nm, "_busycycles"}, nb, el - 1);
    check({nm, "_result"}, result, er);
    check({nm, "_illegal"}, {31'd0, illegal}, {31'd0, ei});
    check({nm, "_zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    int late;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Literal cases pin the model and the DUT together
    check("model_sra", ref_op(4'd7, 32'h80000000, 32'd31, 31), 32'hFFFFFFFF);
    check("model_slt", ref_op(4'd5, 32'hFFFFFFFF, 32'd1, 1), 32'd1);
    run_op("add", 4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1);
    run_op("sub", 4'd1, 32'd5, 32'd5, 32'd0, 1'b0, 1);
    run_op("slt", 4'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
    run_op("sra31", 4'd7, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 32);
    run_op("srl31", 4'd6, 32'h80000000, 32'd31, 32'h00000001, 1'b0, 32);
    run_op("sll0", 4'd4, 32'd1, 32'h20, 32'd1, 1'b0, 1);
    run_op("sll3", 4'd4, 32'h0000000F, 32'd3, 32'h00000078, 1'b0, 4);
    run_op("illegal", 4'hC, 32'h12345678, 32'h9, 32'd0, 1'b1, 1);
    run_op("or_after_ill", 4'd3, 32'd1, 32'd2, 32'd3, 1'b0, 1);

    // Start during a shift is ignored; start in the done cycle is accepted
    @(negedge clk);
    start = 1'b1; ctrl = 4'd4; ta = 32'd3; tb = 32'd4;
    @(negedge clk);
    ctrl = 4'd8; ta = 32'hFFFF0000; tb = 32'h0000FFFF;
    waited = 0;
    while (!done && waited < 40) begin @(negedge clk); waited++; end
    check("b2b_shift_done", {31'd0, done}, 32'd1);
    check("b2b_shift_result", result, 32'h00000030);
    ctrl = 4'd2; ta = 32'h0000F0F0; tb = 32'h0000FF00;
    @(negedge clk);
    start = 1'b0;
    check("b2b_and_done", {31'd0, done}, 32'd1);
    check("b2b_and_result", result, 32'h0000F000);

    // Reset mid-shift aborts with no later done
    @(negedge clk);
    start = 1'b1; ctrl = 4'd4; ta = 32'd1; tb = 32'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    late = 0;
    repeat (25) begin @(negedge clk); if (done) late++; end
    check("abort_no_late_done", late, 0);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) != 0);
      ctrl  = 4'($urandom_range(0, 15));
      ta    = $urandom;
      tb    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu_exec.md
Name: seq_alu_exec

Overview:
- Execution-side consumer of the 4-bit ALU control code produced by the ALU control decoder.
- Performs the decoded operation on two 32-bit operands under a start/done handshake.
- Logic, arithmetic and compare ops complete in one cycle. Shifts run iteratively, one bit per cycle, to save area versus a barrel shifter.
- Sits between the register-file/immediate operand muxes and the writeback/branch logic of the multi-cycle core.

Parameters:
- XLEN, 32, operand and result width.
- SHW, 5, shift-amount width (log2 XLEN); shift amount is b[SHW-1:0].

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk, accepted only when busy=0.
- alu_ctrl  input  4  operation code; sampled with start.
- a  input  XLEN  operand A (rs1); sampled with start.
- b  input  XLEN  operand B (rs2/imm); sampled with start.
- busy  output  1  high while an iterative shift is in progress.
- done  output  1  one-cycle pulse: result/illegal valid for the op just accepted.
- result  output  XLEN  registered result; held until the next accepted op.
- zero  output  1  combinational (result == 0), used for branch compare.
- illegal  output  1  registered; high if the accepted code was unsupported.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, result=0, done=0, busy=0, illegal=0, zero=1, shift counter=0.
- Reset asserted mid-shift aborts the op immediately; no done pulse follows.
- Code map:
  - 0 ADD: a+b, mod 2^32.
  - 1 SUB: a-b, mod 2^32.
  - 2 AND.
  - 3 OR.
  - 4 SLL.
  - 5 SLT: signed compare; result = {31'b0, ($signed(a) < $signed(b))}.
  - 6 SRL: zero fill.
  - 7 SRA: sign fill from bit 31 at each step.
  - 8 XOR.
  - 9-15: result=0, illegal=1, completes as a one-cycle op.
- Overflow and carry are not reported.
- FSM states:
  - IDLE: busy=0.
    - Accepted start with a non-shift code or shamt=0: at that edge result<=computed value (for a shift with shamt=0, result<=a), illegal<=(code>8), done<=1; stay IDLE.
    - Accepted start with a shift code (4/6/7) and shamt!=0: result<=a, cnt<=shamt, latch shift kind, illegal<=0, go SHIFT.
  - SHIFT: busy=1.
    - Each edge: shift result by one in the latched direction/fill, cnt<=cnt-1.
    - On the edge where cnt==1: go IDLE, done<=1.
- Latency, counted in rising edges from the accepting edge to done visible: 1 for non-shift ops; 1+shamt for shifts (max 32 for shamt=31).
- done is high for exactly one cycle. In every other cycle done<=0.
- Handshake:
  - start while busy=1 is ignored; inputs are not re-sampled.
  - start in the same cycle done is high is accepted, so back-to-back ops are allowed.
  - a, b and alu_ctrl need only be valid in the cycle start is high; internal copies are used after that.
- During SHIFT, result shows intermediate values; consumers use result only when done=1 or when idle afterwards.
- zero tracks result at all times, including intermediate shift values.

Test Plan:
- Reset: assert rst_n=0 mid-shift (SLL, shamt=20, after 5 cycles) -> busy=0, done=0, result=0, zero=1 immediately; no later done pulse.
- One-cycle ops:
  - start ADD a=0x7FFFFFFF b=1 -> next cycle done=1, result=0x80000000, zero=0.
  - SUB a=5 b=5 -> result=0, zero=1.
  - SLT a=0xFFFFFFFF b=1 -> result=1.
- Shifts:
  - SRA a=0x80000000 b=31 -> busy high for 31 cycles, done on the 32nd edge, result=0xFFFFFFFF.
  - SRL same operands -> result=0x00000001.
  - SLL a=1 b=0x20 (shamt=0) -> done after 1 edge, result=1.
- Busy/back-to-back: start XOR during SHIFT -> ignored, original shift result delivered. Then start AND a=0xF0F0 b=0xFF00 in the done cycle -> next cycle result=0xF000, done=1.
- Illegal: alu_ctrl=4'hC -> done after 1 edge, illegal=1, result=0. The next legal op (OR 1|2) clears illegal, result=3.
